// File: rtl/bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_rr
// Brief    : BARQ/BAGD bus arbiter with fixed-priority or round-robin grant,
//            programmable strobe delay/length and a reported grant timeout.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter_rr #(
  parameter int DEVICE_MAX_NUMBER = 4,
  parameter int PRIORITY_MODE     = 0,
  parameter int CLK_MAX_TIMEOUT   = 10,
  parameter int STROBE_DELAY      = 2,
  parameter int STROBE_LEN        = 2,
  localparam int c_id_w = (DEVICE_MAX_NUMBER > 1) ? $clog2(DEVICE_MAX_NUMBER) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DEVICE_MAX_NUMBER-1:0] barq_i,
  output logic [DEVICE_MAX_NUMBER-1:0] bagd_o,
  output logic                         target_ready_o,
  input  logic                         address_valid_i,
  output logic                         data_strobe_o,
  output logic                         busy_o,
  output logic [c_id_w-1:0]            grant_id_o,
  output logic                         error_o,
  output logic [c_id_w-1:0]            error_id_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GRANT  = 3'd1,
    S_ADDR   = 3'd2,
    S_DELAY  = 3'd3,
    S_STROBE = 3'd4,
    S_END    = 3'd5
  } state_t;

  localparam logic [3:0]      c_dly_ld = 4'(STROBE_DELAY - 1);
  localparam logic [3:0]      c_len_ld = 4'(STROBE_LEN - 1);
  localparam logic [9:0]      c_tmo    = 10'(CLK_MAX_TIMEOUT);
  localparam logic [c_id_w:0] c_n      = (c_id_w + 1)'(DEVICE_MAX_NUMBER);

  state_t                         r_state, w_state_nxt;
  logic [DEVICE_MAX_NUMBER-1:0]   r_bagd, w_bagd_nxt;
  logic                           r_tready, w_tready_nxt;
  logic                           r_strobe, w_strobe_nxt;
  logic [c_id_w-1:0]              r_grant_id, w_grant_id_nxt;
  logic                           r_err, w_err_nxt;
  logic [c_id_w-1:0]              r_err_id, w_err_id_nxt;
  logic [3:0]                     r_dcnt, w_dcnt_nxt;
  logic [3:0]                     r_lcnt, w_lcnt_nxt;
  logic [9:0]                     r_tcnt, w_tcnt_nxt, w_tcnt_inc;
  logic                           w_timeout, w_abort;

  logic [c_id_w-1:0]              w_start, w_off, w_win;
  logic [DEVICE_MAX_NUMBER-1:0]   w_rot, w_onehot;
  logic [c_id_w:0]                w_sum;

  // Rotate requests so the search always starts at bit 0, then rotate back.
  always_comb begin
    w_rot = DEVICE_MAX_NUMBER'({barq_i, barq_i} >> w_start);
    w_off = '0;
    for (int i = DEVICE_MAX_NUMBER - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = c_id_w'(i);
    end
    w_sum = {1'b0, w_start} + {1'b0, w_off};
    if (w_sum >= c_n) w_sum = w_sum - c_n;
    w_win    = w_sum[c_id_w-1:0];
    w_onehot = '0;
    for (int i = 0; i < DEVICE_MAX_NUMBER; i++) begin
      w_onehot[i] = (w_win == c_id_w'(i));
    end
  end

  generate
    if (PRIORITY_MODE == 1) begin : g_rr
      localparam logic [c_id_w-1:0] c_last = c_id_w'(DEVICE_MAX_NUMBER - 1);
      logic [c_id_w-1:0] r_ptr;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ptr <= '0;
        end else if ((r_state == S_IDLE) && (|barq_i)) begin
          r_ptr <= (w_win == c_last) ? '0 : w_win + 1'b1;
        end
      end

      assign w_start = r_ptr;
    end else begin : g_fixed
      assign w_start = '0;
    end
  endgenerate

  always_comb begin
    w_state_nxt    = r_state;
    w_bagd_nxt     = r_bagd;
    w_tready_nxt   = r_tready;
    w_strobe_nxt   = r_strobe;
    w_grant_id_nxt = r_grant_id;
    w_err_nxt      = 1'b0;
    w_err_id_nxt   = r_err_id;
    w_dcnt_nxt     = r_dcnt;
    w_lcnt_nxt     = r_lcnt;
    w_tcnt_nxt     = r_tcnt;
    w_tcnt_inc     = r_tcnt + 10'd1;
    w_timeout      = (w_tcnt_inc == c_tmo);
    w_abort        = ~|(barq_i & r_bagd);

    case (r_state)
      S_IDLE: begin
        if (|barq_i) begin
          w_state_nxt    = S_GRANT;
          w_bagd_nxt     = w_onehot;
          w_grant_id_nxt = w_win;
          w_tcnt_nxt     = '0;
        end
      end

      S_GRANT, S_ADDR, S_DELAY: begin
        w_tcnt_nxt = w_tcnt_inc;
        // Timeout outranks both a dropped request and a late address_valid.
        if (w_timeout || w_abort) begin
          w_state_nxt  = S_END;
          w_bagd_nxt   = '0;
          w_tready_nxt = 1'b0;
          w_strobe_nxt = 1'b0;
          if (w_timeout) begin
            w_err_nxt    = 1'b1;
            w_err_id_nxt = r_grant_id;
          end
        end else if (r_state == S_GRANT) begin
          w_tready_nxt = 1'b1;
          w_state_nxt  = S_ADDR;
        end else if (r_state == S_ADDR) begin
          if (address_valid_i) begin
            if (c_dly_ld == 4'd0) begin
              w_state_nxt  = S_STROBE;
              w_strobe_nxt = 1'b1;
              w_lcnt_nxt   = c_len_ld;
            end else begin
              w_state_nxt = S_DELAY;
              w_dcnt_nxt  = c_dly_ld;
            end
          end
        end else if (r_dcnt == 4'd1) begin
          w_state_nxt  = S_STROBE;
          w_strobe_nxt = 1'b1;
          w_lcnt_nxt   = c_len_ld;
        end else begin
          w_dcnt_nxt = r_dcnt - 4'd1;
        end
      end

      S_STROBE: begin
        if (r_lcnt == 4'd0) begin
          w_state_nxt  = S_END;
          w_bagd_nxt   = '0;
          w_tready_nxt = 1'b0;
          w_strobe_nxt = 1'b0;
        end else begin
          w_lcnt_nxt = r_lcnt - 4'd1;
        end
      end

      S_END: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_bagd     <= '0;
      r_tready   <= 1'b0;
      r_strobe   <= 1'b0;
      r_grant_id <= '0;
      r_err      <= 1'b0;
      r_err_id   <= '0;
      r_dcnt     <= '0;
      r_lcnt     <= '0;
      r_tcnt     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_bagd     <= w_bagd_nxt;
      r_tready   <= w_tready_nxt;
      r_strobe   <= w_strobe_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_err      <= w_err_nxt;
      r_err_id   <= w_err_id_nxt;
      r_dcnt     <= w_dcnt_nxt;
      r_lcnt     <= w_lcnt_nxt;
      r_tcnt     <= w_tcnt_nxt;
    end
  end

  assign bagd_o         = r_bagd;
  assign target_ready_o = r_tready;
  assign data_strobe_o  = r_strobe;
  assign busy_o         = (r_state != S_IDLE);
  assign grant_id_o     = r_grant_id;
  assign error_o        = r_err;
  assign error_id_o     = r_err_id;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter_rr
// Brief    : Randomised bench for three arbiter configurations against a
//            timestamp-based transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter_rr;

  localparam int NI = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [3:0] barq [NI];
  logic       av   [NI];

  logic [3:0] bagd_a, bagd_b;
  logic [0:0] bagd_c;
  logic       tr_a, tr_b, tr_c;
  logic       ds_a, ds_b, ds_c;
  logic       busy_a, busy_b, busy_c;
  logic       err_a, err_b, err_c;
  logic [1:0] gid_a, gid_b, eid_a, eid_b;
  logic [0:0] gid_c, eid_c;

  // Instance configurations: 0 fixed N=4, 1 round-robin N=4, 2 round-robin N=1.
  int cfg_n  [NI] = '{4, 4, 1};
  int cfg_rr [NI] = '{0, 1, 1};
  int cfg_to [NI] = '{10, 6, 10};
  int cfg_sd [NI] = '{2, 3, 1};
  int cfg_sl [NI] = '{2, 2, 5};

  // Model: edge indices of grant, sampled address_valid and END entry.
  int m_tg [NI];
  int m_ta [NI];
  int m_te [NI];
  int m_own [NI];
  int m_gid [NI];
  int m_eid [NI];
  int m_ptr [NI];
  bit m_err [NI];
  int cyc;

  int n_total;
  int n_bad;

  always #5 clk = ~clk;

  bus_arbiter_rr #(
    .DEVICE_MAX_NUMBER(4), .PRIORITY_MODE(0), .CLK_MAX_TIMEOUT(10),
    .STROBE_DELAY(2), .STROBE_LEN(2)
  ) u_fix (
    .clk(clk), .rst_n(rst_n), .barq_i(barq[0]), .bagd_o(bagd_a),
    .target_ready_o(tr_a), .address_valid_i(av[0]), .data_strobe_o(ds_a),
    .busy_o(busy_a), .grant_id_o(gid_a), .error_o(err_a), .error_id_o(eid_a)
  );

  bus_arbiter_rr #(
    .DEVICE_MAX_NUMBER(4), .PRIORITY_MODE(1), .CLK_MAX_TIMEOUT(6),
    .STROBE_DELAY(3), .STROBE_LEN(2)
  ) u_rr (
    .clk(clk), .rst_n(rst_n), .barq_i(barq[1]), .bagd_o(bagd_b),
    .target_ready_o(tr_b), .address_valid_i(av[1]), .data_strobe_o(ds_b),
    .busy_o(busy_b), .grant_id_o(gid_b), .error_o(err_b), .error_id_o(eid_b)
  );

  bus_arbiter_rr #(
    .DEVICE_MAX_NUMBER(1), .PRIORITY_MODE(1), .CLK_MAX_TIMEOUT(10),
    .STROBE_DELAY(1), .STROBE_LEN(5)
  ) u_one (
    .clk(clk), .rst_n(rst_n), .barq_i(barq[2][0:0]), .bagd_o(bagd_c),
    .target_ready_o(tr_c), .address_valid_i(av[2]), .data_strobe_o(ds_c),
    .busy_o(busy_c), .grant_id_o(gid_c), .error_o(err_c), .error_id_o(eid_c)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_tg[k]  = -1;
      m_ta[k]  = -1;
      m_te[k]  = -1;
      m_own[k] = 0;
      m_gid[k] = 0;
      m_eid[k] = 0;
      m_ptr[k] = 0;
      m_err[k] = 1'b0;
    end
  endtask

  function automatic int pick_winner(input int k, input logic [3:0] req);
    for (int i = 0; i < cfg_n[k]; i++) begin
      int j = (m_ptr[k] + i) % cfg_n[k];
      if (req[j]) return j;
    end
    return 0;
  endfunction

  task automatic model_step(input int n);
    for (int k = 0; k < NI; k++) begin
      logic [3:0] req = barq[k] & 4'((1 << cfg_n[k]) - 1);
      int ss;
      if (m_tg[k] < 0 || (m_te[k] >= 0 && n >= m_te[k] + 2)) begin
        if (req != 4'd0) begin
          m_own[k] = pick_winner(k, req);
          m_gid[k] = m_own[k];
          m_tg[k]  = n;
          m_ta[k]  = -1;
          m_te[k]  = -1;
          m_err[k] = 1'b0;
          if (cfg_rr[k] != 0) m_ptr[k] = (m_own[k] + 1) % cfg_n[k];
        end
      end else if (m_te[k] < 0) begin
        ss = (m_ta[k] >= 0) ? m_ta[k] + cfg_sd[k] - 1 : n;
        if (n <= ss) begin
          if (n - m_tg[k] == cfg_to[k]) begin
            m_te[k]  = n;
            m_err[k] = 1'b1;
            m_eid[k] = m_own[k];
          end else if (!req[m_own[k]]) begin
            m_te[k] = n;
          end else if (m_ta[k] < 0 && n >= m_tg[k] + 2 && av[k]) begin
            m_ta[k] = n;
          end
        end else if (n == ss + cfg_sl[k]) begin
          m_te[k] = n;
        end
      end
    end
  endtask

  function automatic bit exp_live(input int k);
    return (m_tg[k] >= 0) && (m_te[k] < 0 || cyc < m_te[k]);
  endfunction

  function automatic bit exp_strobe(input int k);
    return exp_live(k) && m_ta[k] >= 0 && cyc >= m_ta[k] + cfg_sd[k] - 1;
  endfunction

  task automatic check_inst(input int k);
    logic [31:0] o_bagd, o_tr, o_ds, o_busy, o_gid, o_err, o_eid;
    bit live;
    case (k)
      0: begin
        o_bagd = 32'(bagd_a); o_tr = 32'(tr_a); o_ds = 32'(ds_a); o_busy = 32'(busy_a);
        o_gid = 32'(gid_a); o_err = 32'(err_a); o_eid = 32'(eid_a);
      end
      1: begin
        o_bagd = 32'(bagd_b); o_tr = 32'(tr_b); o_ds = 32'(ds_b); o_busy = 32'(busy_b);
        o_gid = 32'(gid_b); o_err = 32'(err_b); o_eid = 32'(eid_b);
      end
      default: begin
        o_bagd = 32'(bagd_c); o_tr = 32'(tr_c); o_ds = 32'(ds_c); o_busy = 32'(busy_c);
        o_gid = 32'(gid_c); o_err = 32'(err_c); o_eid = 32'(eid_c);
      end
    endcase
    live = exp_live(k);
    check_eq($sformatf("i%0d.bagd", k), o_bagd, live ? (32'd1 << m_own[k]) : 32'd0);
    check_eq($sformatf("i%0d.target_ready", k), o_tr, 32'(live && cyc >= m_tg[k] + 1));
    check_eq($sformatf("i%0d.data_strobe", k), o_ds, 32'(exp_strobe(k)));
    check_eq($sformatf("i%0d.busy", k), o_busy,
             32'(m_tg[k] >= 0 && (m_te[k] < 0 || cyc <= m_te[k])));
    check_eq($sformatf("i%0d.grant_id", k), o_gid, 32'(m_gid[k]));
    check_eq($sformatf("i%0d.error", k), o_err, 32'(m_err[k] && m_te[k] == cyc));
    check_eq($sformatf("i%0d.error_id", k), o_eid, 32'(m_eid[k]));
  endtask

  // seg 0: random; 1: held contention, address_valid tied high;
  // 2: address_valid never (timeouts); 3: random with frequent owner drops.
  task automatic drive_inputs(input int seg);
    for (int k = 0; k < NI; k++) begin
      for (int j = 0; j < cfg_n[k]; j++) begin
        bit own  = (m_tg[k] >= 0) && (m_own[k] == j);
        bit done = own && (m_te[k] >= 0);
        if (seg == 1)         barq[k][j] = (k == 0) ? ((j % 2) == 1) : 1'b1;
        else if (!barq[k][j]) barq[k][j] = ($urandom_range(0, 3) == 0);
        else if (done)        barq[k][j] = ($urandom_range(0, 1) == 0);
        else if (own)         barq[k][j] = ($urandom_range(0, (seg == 3) ? 12 : 60) != 0);
      end
      av[k] = (seg == 1) ? 1'b1 : (seg == 2) ? 1'b0 : ($urandom_range(0, 2) == 0);
    end
  endtask

  task automatic run_cycle(input int seg);
    @(posedge clk);
    if (rst_n) begin
      cyc++;
      model_step(cyc);
    end
    @(negedge clk);
    for (int k = 0; k < NI; k++) check_inst(k);
    drive_inputs(seg);
  endtask

  initial begin
    bit found;
    n_total = 0;
    n_bad   = 0;
    cyc     = 0;
    model_reset();
    for (int k = 0; k < NI; k++) begin
      barq[k] = 4'd0;
      av[k]   = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) check_inst(k);
    rst_n = 1'b1;
    drive_inputs(0);

    repeat (400) run_cycle(0);
    repeat (150) run_cycle(1);
    repeat (200) run_cycle(2);

    // Pull reset asynchronously while the fixed-priority instance strobes.
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      run_cycle(3);
      found = exp_strobe(0);
    end
    check_eq("strobe_before_reset", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < NI; k++) check_inst(k);
    @(negedge clk);
    for (int k = 0; k < NI; k++) check_inst(k);
    rst_n = 1'b1;

    repeat (400) run_cycle(3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
